// File: rtl/dvs_ravens_pkg.sv
// -----------------------------------------------------------------------------
// dvs_ravens_pkg
// Shared widths and types for the DVS camera -> RAVENS event path.
//   DVS_X_ADDR_BITS / DVS_Y_ADDR_BITS : pixel address widths
//   TIMESTAMP_US_BITS                 : event timestamp width (microseconds)
//   dvs_event_t                       : one address event {x, y, timestamp, polarity}
//   out_state_e                       : arbiter output register state
// -----------------------------------------------------------------------------
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS   = 10;
  localparam int DVS_Y_ADDR_BITS   = 10;
  localparam int TIMESTAMP_US_BITS = 24;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic [TIMESTAMP_US_BITS-1:0] timestamp;
    logic                         polarity;
  } dvs_event_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/dvs_event_slot.sv
// -----------------------------------------------------------------------------
// dvs_event_slot
// One-entry holding register for a single DVS receiver channel.
// Optional feature macro: DVS_ARB_DROP_COUNT_EN (saturating drop counter).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   strobe      : single-cycle new-event pulse from the receiver
//   event_in    : event carried with the strobe
//   grant       : slot contents are moved to the output register this cycle
//   full        : slot occupied
//   event_out   : registered slot contents
//   drop_count  : saturating count of dropped events (macro only)
// -----------------------------------------------------------------------------
module dvs_event_slot
  import dvs_ravens_pkg::*;
#(
  parameter int DROP_CNT_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  dvs_event_t event_in,
  input  logic       grant,
  output logic       full,
  output dvs_event_t event_out
`ifdef DVS_ARB_DROP_COUNT_EN
  ,
  output logic [DROP_CNT_BITS-1:0] drop_count
`endif
);

  if (DROP_CNT_BITS < 1) begin : g_param_check
    $error("dvs_event_slot: DROP_CNT_BITS must be at least 1");
  end

  logic       full_reg;
  dvs_event_t event_reg;
  logic       fill;

  // A slot being granted this cycle is vacated, so a simultaneous strobe
  // refills it instead of being dropped.
  assign fill = strobe && (!full_reg || grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg  <= 1'b0;
      event_reg <= '0;
    end else begin
      if (fill) begin
        full_reg  <= 1'b1;
        event_reg <= event_in;
      end else if (grant) begin
        full_reg <= 1'b0;
      end
    end
  end

  assign full      = full_reg;
  assign event_out = event_reg;

`ifdef DVS_ARB_DROP_COUNT_EN
  logic                     drop;
  logic [DROP_CNT_BITS-1:0] drop_cnt_reg;

  assign drop = strobe && full_reg && !grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop && !(&drop_cnt_reg)) begin
      drop_cnt_reg <= drop_cnt_reg + DROP_CNT_BITS'(1);
    end
  end

  assign drop_count = drop_cnt_reg;
`endif

endmodule

// File: rtl/dvs_event_arbiter.sv
// -----------------------------------------------------------------------------
// dvs_event_arbiter
// Round-robin arbiter sharing one registered valid/ready event port between
// NUM_SRC DVS receiver channels. Each channel has a one-entry slot; events
// arriving while the slot is occupied (and not being granted) are dropped.
// Optional feature macro: DVS_ARB_DROP_COUNT_EN adds per-source saturating
// drop counters and the drop_count port.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   src_new_event[i]       : per-source event strobe
//   src_event_x/y/timestamp: packed per-source fields, source i at [i*W +: W]
//   src_event_polarity[i]  : per-source polarity
//   out_valid / out_ready  : output handshake
//   out_x/y/timestamp/polarity, out_src : granted event and its source index
//   slot_full              : per-source slot occupancy
//   drop_count             : packed per-source drop counters (macro only)
// -----------------------------------------------------------------------------
module dvs_event_arbiter
  import dvs_ravens_pkg::*;
#(
  parameter  int NUM_SRC       = 2,
  parameter  int DROP_CNT_BITS = 16,
  localparam int SRC_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SRC-1:0]                   src_new_event,
  input  logic [NUM_SRC*DVS_X_ADDR_BITS-1:0]   src_event_x,
  input  logic [NUM_SRC*DVS_Y_ADDR_BITS-1:0]   src_event_y,
  input  logic [NUM_SRC*TIMESTAMP_US_BITS-1:0] src_event_timestamp,
  input  logic [NUM_SRC-1:0]                   src_event_polarity,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DVS_X_ADDR_BITS-1:0]           out_x,
  output logic [DVS_Y_ADDR_BITS-1:0]           out_y,
  output logic [TIMESTAMP_US_BITS-1:0]         out_timestamp,
  output logic                                 out_polarity,
  output logic [SRC_W-1:0]                     out_src,
  output logic [NUM_SRC-1:0]                   slot_full
`ifdef DVS_ARB_DROP_COUNT_EN
  ,
  output logic [NUM_SRC*DROP_CNT_BITS-1:0]     drop_count
`endif
);

  if (NUM_SRC < 2 || NUM_SRC > 8 || DROP_CNT_BITS < 1) begin : g_param_check
    $error("dvs_event_arbiter: NUM_SRC must be 2..8 and DROP_CNT_BITS >= 1");
  end

  out_state_e       state_reg;
  out_state_e       state_next;
  dvs_event_t       out_event_reg;
  logic [SRC_W-1:0] out_src_reg;
  logic [SRC_W-1:0] last_grant_reg;

  dvs_event_t       slot_event [NUM_SRC];
  logic [NUM_SRC-1:0] slot_grant;

  logic             out_free;
  logic             grant_found;
  logic             grant_en;
  logic [SRC_W-1:0] grant_idx;

  // ---------------------------------------------------------------------------
  // Per-source slots
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
    dvs_event_t ev_in;

    assign ev_in.x         = src_event_x[gi*DVS_X_ADDR_BITS +: DVS_X_ADDR_BITS];
    assign ev_in.y         = src_event_y[gi*DVS_Y_ADDR_BITS +: DVS_Y_ADDR_BITS];
    assign ev_in.timestamp = src_event_timestamp[gi*TIMESTAMP_US_BITS +: TIMESTAMP_US_BITS];
    assign ev_in.polarity  = src_event_polarity[gi];

    assign slot_grant[gi] = grant_en && (grant_idx == SRC_W'(gi));

    dvs_event_slot #(
      .DROP_CNT_BITS(DROP_CNT_BITS)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .strobe    (src_new_event[gi]),
      .event_in  (ev_in),
      .grant     (slot_grant[gi]),
      .full      (slot_full[gi]),
      .event_out (slot_event[gi])
`ifdef DVS_ARB_DROP_COUNT_EN
      ,
      .drop_count(drop_count[gi*DROP_CNT_BITS +: DROP_CNT_BITS])
`endif
    );
  end

  // ---------------------------------------------------------------------------
  // Round-robin search. Only registered slot occupancy is considered, so an
  // event never passes from strobe to output in a single cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!grant_found && slot_full[j] &&
            (j == ((int'(last_grant_reg) + k) % NUM_SRC))) begin
          grant_found = 1'b1;
          grant_idx   = SRC_W'(j);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    out_free   = (state_reg == OUT_EMPTY) || out_ready;
    grant_en   = out_free && grant_found;
    state_next = state_reg;
    if (out_free) begin
      state_next = grant_found ? OUT_VALID : OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= OUT_EMPTY;
      out_event_reg  <= '0;
      out_src_reg    <= '0;
      last_grant_reg <= SRC_W'(NUM_SRC - 1);
    end else begin
      state_reg <= state_next;
      if (grant_en) begin
        out_event_reg  <= slot_event[grant_idx];
        out_src_reg    <= grant_idx;
        last_grant_reg <= grant_idx;
      end
    end
  end

  assign out_valid     = (state_reg == OUT_VALID);
  assign out_x         = out_event_reg.x;
  assign out_y         = out_event_reg.y;
  assign out_timestamp = out_event_reg.timestamp;
  assign out_polarity  = out_event_reg.polarity;
  assign out_src       = out_src_reg;

endmodule

// File: tb/tb_dvs_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dvs_event_arbiter
// Bench for dvs_event_arbiter: a 2-source instance (dut_a) and a 4-source
// instance with 2-bit drop counters (dut_b). Expected transfers are queued
// when stimulus is driven and checked by per-instance monitors on each
// accepted handshake. Drop counter checks apply with DVS_ARB_DROP_COUNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dvs_event_arbiter;
  import dvs_ravens_pkg::*;

  localparam int XB = DVS_X_ADDR_BITS;
  localparam int YB = DVS_Y_ADDR_BITS;
  localparam int TB = TIMESTAMP_US_BITS;

  typedef struct {
    logic [2:0] src;
    dvs_event_t ev;
  } exp_t;

  logic clk;
  logic rst;

  // dut_a: NUM_SRC = 2
  logic [1:0]      new_a;
  logic [2*XB-1:0] x_a;
  logic [2*YB-1:0] y_a;
  logic [2*TB-1:0] ts_a;
  logic [1:0]      pol_a;
  logic            valid_a;
  logic            ready_a;
  logic [XB-1:0]   ox_a;
  logic [YB-1:0]   oy_a;
  logic [TB-1:0]   ots_a;
  logic            opol_a;
  logic            osrc_a;
  logic [1:0]      full_a;
  dvs_event_t      oev_a;

  // dut_b: NUM_SRC = 4, DROP_CNT_BITS = 2
  logic [3:0]      new_b;
  logic [4*XB-1:0] x_b;
  logic [4*YB-1:0] y_b;
  logic [4*TB-1:0] ts_b;
  logic [3:0]      pol_b;
  logic            valid_b;
  logic            ready_b;
  logic [XB-1:0]   ox_b;
  logic [YB-1:0]   oy_b;
  logic [TB-1:0]   ots_b;
  logic            opol_b;
  logic [1:0]      osrc_b;
  logic [3:0]      full_b;
  dvs_event_t      oev_b;

`ifdef DVS_ARB_DROP_COUNT_EN
  logic [31:0]     drop_a;
  logic [7:0]      drop_b;
`endif

  assign oev_a = {ox_a, oy_a, ots_a, opol_a};
  assign oev_b = {ox_b, oy_b, ots_b, opol_b};

  int   checks = 0;
  int   fails  = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  dvs_event_arbiter #(.NUM_SRC(2)) dut_a (
    .clk                (clk),
    .rst                (rst),
    .src_new_event      (new_a),
    .src_event_x        (x_a),
    .src_event_y        (y_a),
    .src_event_timestamp(ts_a),
    .src_event_polarity (pol_a),
    .out_valid          (valid_a),
    .out_ready          (ready_a),
    .out_x              (ox_a),
    .out_y              (oy_a),
    .out_timestamp      (ots_a),
    .out_polarity       (opol_a),
    .out_src            (osrc_a),
    .slot_full          (full_a)
`ifdef DVS_ARB_DROP_COUNT_EN
    ,
    .drop_count         (drop_a)
`endif
  );

  dvs_event_arbiter #(.NUM_SRC(4), .DROP_CNT_BITS(2)) dut_b (
    .clk                (clk),
    .rst                (rst),
    .src_new_event      (new_b),
    .src_event_x        (x_b),
    .src_event_y        (y_b),
    .src_event_timestamp(ts_b),
    .src_event_polarity (pol_b),
    .out_valid          (valid_b),
    .out_ready          (ready_b),
    .out_x              (ox_b),
    .out_y              (oy_b),
    .out_timestamp      (ots_b),
    .out_polarity       (opol_b),
    .out_src            (osrc_b),
    .slot_full          (full_b)
`ifdef DVS_ARB_DROP_COUNT_EN
    ,
    .drop_count         (drop_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Monitors: one line per accepted transfer, compared against the queue.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      $display("xfer A src=%0d x=%0d y=%0d ts=%0d pol=%0d", osrc_a, ox_a, oy_a, ots_a, opol_a);
      checks++;
      if (q_a.size() == 0) begin
        fails++;
        $display("FAIL xfer_a_unexpected: got src=%0d x=%0d, required no transfer", osrc_a, ox_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        if (3'(osrc_a) !== e.src || oev_a !== e.ev) begin
          fails++;
          $display("FAIL xfer_a: got src=%0d ev=%h, required src=%0d ev=%h", osrc_a, oev_a, e.src, e.ev);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_b && ready_b) begin
      $display("xfer B src=%0d x=%0d y=%0d ts=%0d pol=%0d", osrc_b, ox_b, oy_b, ots_b, opol_b);
      checks++;
      if (q_b.size() == 0) begin
        fails++;
        $display("FAIL xfer_b_unexpected: got src=%0d x=%0d, required no transfer", osrc_b, ox_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        if (3'(osrc_b) !== e.src || oev_b !== e.ev) begin
          fails++;
          $display("FAIL xfer_b: got src=%0d ev=%h, required src=%0d ev=%h", osrc_b, oev_b, e.src, e.ev);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic dvs_event_t mk_ev(input int x, input int y, input int ts, input int pol);
    dvs_event_t e;
    e.x         = XB'(x);
    e.y         = YB'(y);
    e.timestamp = TB'(ts);
    e.polarity  = pol[0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input dvs_event_t e);
    x_a[i*XB +: XB]  = e.x;
    y_a[i*YB +: YB]  = e.y;
    ts_a[i*TB +: TB] = e.timestamp;
    pol_a[i]         = e.polarity;
  endtask

  task automatic set_b(input int i, input dvs_event_t e);
    x_b[i*XB +: XB]  = e.x;
    y_b[i*YB +: YB]  = e.y;
    ts_b[i*TB +: TB] = e.timestamp;
    pol_b[i]         = e.polarity;
  endtask

  task automatic push_a(input int src, input dvs_event_t e);
    exp_t r;
    r.src = 3'(src);
    r.ev  = e;
    q_a.push_back(r);
  endtask

  task automatic push_b(input int src, input dvs_event_t e);
    exp_t r;
    r.src = 3'(src);
    r.ev  = e;
    q_b.push_back(r);
  endtask

  task automatic do_reset();
    new_a = '0;
    new_b = '0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    checks++;
    if (valid_a !== 1'b0 || full_a !== 2'b00 || oev_a !== '0 || osrc_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_values_a: got valid=%b full=%b ev=%h src=%b, required 0", valid_a, full_a, oev_a, osrc_a);
    end
    checks++;
    if (valid_b !== 1'b0 || full_b !== 4'b0000 || oev_b !== '0 || osrc_b !== 2'b00) begin
      fails++;
      $display("FAIL reset_values_b: got valid=%b full=%b ev=%h src=%b, required 0", valid_b, full_b, oev_b, osrc_b);
    end
    // Fill both slots with the output stalled, then reset mid-stream.
    ready_a = 1'b0;
    set_a(0, mk_ev(7, 7, 7, 1));
    set_a(1, mk_ev(8, 8, 8, 0));
    new_a = 2'b11;
    tick();
    tick();
    new_a = 2'b00;
    checks++;
    if (full_a !== 2'b11 || valid_a !== 1'b1) begin
      fails++;
      $display("FAIL reset_prefill: got full=%b valid=%b, required full=11 valid=1", full_a, valid_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (valid_a !== 1'b0 || full_a !== 2'b00 || osrc_a !== 1'b0 || oev_a !== '0) begin
      fails++;
      $display("FAIL reset_midstream: got valid=%b full=%b src=%b ev=%h, required all 0", valid_a, full_a, osrc_a, oev_a);
    end
`ifdef DVS_ARB_DROP_COUNT_EN
    checks++;
    if (drop_a !== 32'd0) begin
      fails++;
      $display("FAIL reset_drop_count: got %h, required 0", drop_a);
    end
`endif
    tick();
    rst     = 1'b0;
    ready_a = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (valid_a !== 1'b0) begin
        fails++;
        $display("FAIL reset_quiet_c%0d: got out_valid=%b, required 0", c, valid_a);
      end
    end
  endtask

  task automatic test_single();
    dvs_event_t e;
    do_reset();
    ready_a = 1'b1;
    e = mk_ev(100, 50, 1234, 1);
    set_a(1, e);
    push_a(1, e);
    new_a = 2'b10;
    tick();
    new_a = 2'b00;
    checks++;
    if (full_a !== 2'b10 || valid_a !== 1'b0) begin
      fails++;
      $display("FAIL single_n1: got full=%b valid=%b, required full=10 valid=0", full_a, valid_a);
    end
    tick();
    checks++;
    if (valid_a !== 1'b1 || osrc_a !== 1'b1 || ox_a !== XB'(100) || oy_a !== YB'(50) ||
        ots_a !== TB'(1234) || opol_a !== 1'b1) begin
      fails++;
      $display("FAIL single_n2: got valid=%b src=%0d x=%0d y=%0d ts=%0d pol=%b, required 1 1 100 50 1234 1",
               valid_a, osrc_a, ox_a, oy_a, ots_a, opol_a);
    end
    tick();
    checks++;
    if (valid_a !== 1'b0 || full_a !== 2'b00) begin
      fails++;
      $display("FAIL single_n3: got valid=%b full=%b, required 0 00", valid_a, full_a);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ready_a = 1'b1;
    for (int r = 0; r < 2; r++) begin
      dvs_event_t e0;
      dvs_event_t e1;
      e0 = mk_ev(11 + 22*r, 200 + r, 5000 + r, 0);
      e1 = mk_ev(22 + 22*r, 300 + r, 6000 + r, 1);
      set_a(0, e0);
      set_a(1, e1);
      push_a(0, e0);
      push_a(1, e1);
      new_a = 2'b11;
      tick();
      new_a = 2'b00;
      tick();
      checks++;
      if (valid_a !== 1'b1 || osrc_a !== 1'b0) begin
        fails++;
        $display("FAIL simul_first_r%0d: got valid=%b src=%0d, required 1 0", r, valid_a, osrc_a);
      end
      tick();
      checks++;
      if (valid_a !== 1'b1 || osrc_a !== 1'b1) begin
        fails++;
        $display("FAIL simul_second_r%0d: got valid=%b src=%0d, required 1 1", r, valid_a, osrc_a);
      end
      tick();
      checks++;
      if (valid_a !== 1'b0) begin
        fails++;
        $display("FAIL simul_idle_r%0d: got valid=%b, required 0", r, valid_a);
      end
    end
  endtask

  task automatic test_backpressure();
    dvs_event_t e;
    ready_a = 1'b0;
    e = mk_ev(300, 400, 99999, 0);
    set_a(0, e);
    new_a = 2'b01;
    tick();
    new_a = 2'b00;
    tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (valid_a !== 1'b1 || oev_a !== e || osrc_a !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold_c%0d: got valid=%b src=%0d ev=%h, required 1 0 %h", c, valid_a, osrc_a, oev_a, e);
      end
      tick();
    end
    push_a(0, e);
    ready_a = 1'b1;
    tick();
    checks++;
    if (valid_a !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release: got valid=%b, required 0", valid_a);
    end
    tick();
    checks++;
    if (q_a.size() != 0) begin
      fails++;
      $display("FAIL backpressure_pending: got %0d queued, required 0", q_a.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ready_a = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_a(0, mk_ev(k, k, k, k));
      new_a = 2'b01;
      tick();
    end
    new_a = 2'b00;
    checks++;
    if (valid_a !== 1'b1 || ox_a !== XB'(1) || full_a !== 2'b01) begin
      fails++;
      $display("FAIL overflow_hold: got valid=%b x=%0d full=%b, required 1 1 01", valid_a, ox_a, full_a);
    end
`ifdef DVS_ARB_DROP_COUNT_EN
    checks++;
    if (drop_a[15:0] !== 16'd3 || drop_a[31:16] !== 16'd0) begin
      fails++;
      $display("FAIL overflow_drops: got %h, required src0=3 src1=0", drop_a);
    end
`endif
    push_a(0, mk_ev(1, 1, 1, 1));
    push_a(0, mk_ev(2, 2, 2, 2));
    ready_a = 1'b1;
    repeat (3) tick();
    checks++;
    if (q_a.size() != 0 || valid_a !== 1'b0) begin
      fails++;
      $display("FAIL overflow_drain: got %0d queued valid=%b, required 0 0", q_a.size(), valid_a);
    end
  endtask

`ifdef DVS_ARB_DROP_COUNT_EN
  task automatic test_saturation();
    do_reset();
    ready_b = 1'b0;
    set_b(2, mk_ev(55, 66, 77, 1));
    new_b = 4'b0100;
    repeat (8) tick();
    new_b = 4'b0000;
    checks++;
    if (drop_b[5:4] !== 2'b11 || drop_b[3:0] !== 4'b0000 || drop_b[7:6] !== 2'b00) begin
      fails++;
      $display("FAIL drop_saturate: got %b, required src2=11 others 0", drop_b);
    end
  endtask
`endif

  task automatic test_fairness();
    do_reset();
    ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_b(i, mk_ev(100 + i, 10 * i, 1000 + i, i));
    end
    // 16 strobe cycles produce 3 grants per... continuous rotation: 15 grants
    // while strobing plus 4 to drain the refilled slots.
    for (int k = 0; k < 19; k++) begin
      push_b(k % 4, mk_ev(100 + (k % 4), 10 * (k % 4), 1000 + (k % 4), k % 4));
    end
    new_b = 4'b1111;
    repeat (16) tick();
    new_b = 4'b0000;
    repeat (8) tick();
    checks++;
    if (q_b.size() != 0 || valid_b !== 1'b0) begin
      fails++;
      $display("FAIL fairness_drain: got %0d queued valid=%b, required 0 0", q_b.size(), valid_b);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    new_a   = '0;
    x_a     = '0;
    y_a     = '0;
    ts_a    = '0;
    pol_a   = '0;
    ready_a = 1'b0;
    new_b   = '0;
    x_b     = '0;
    y_b     = '0;
    ts_b    = '0;
    pol_b   = '0;
    ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
`ifdef DVS_ARB_DROP_COUNT_EN
    test_saturation();
`endif
    test_fairness();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
